serial_arith_unit: RTL and testbench
====================================

// Module: serial_arith_unit
// PURPOSE
//  Bit-serial W-bit arithmetic engine built around a 1-bit arithmetic slice (Ai,Bi,Ci,S1,S0 -> H,Co).
//  Accepts an operand pair plus opcode and walks the slice LSB-first, one bit per clock.
//  Registers the carry between bits and assembles the W-bit result.
//  Sits between the operand/instruction source and the result consumer; valid/ready handshake on both sides.
// PARAMETERS
//  W        8   operand/result width in bits (>=2)
//  CNT_W    $clog2(W)   bit-counter width (derived, not overridden)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     operand/opcode valid
//  in_ready     out  1     unit can accept (high only in IDLE)
//  op           in   2     {S1,S0} opcode, see package
//  a            in   W     operand A
//  b            in   W     operand B
//  ci           in   1     carry-in, used by OP_ADD only
//  out_valid    out  1     result valid (DONE state)
//  out_ready    in   1     consumer accepts result
//  result       out  W     assembled H bits
//  co           out  1     final carry out of bit W-1
//  zero, ovf    out  1 ea  only with ARITH_FLAGS_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1 after release, out_valid=0, result=0, co=0, counter=0, carry reg=0.
//   Reset is async assert/deassert-to-clock; reset mid-RUN or mid-DONE aborts, result discarded.
//  Opcodes (S1,S0): 00 ADD H=A+B+ci | 01 SUB A+~B, carry0=1 | 10 INC A+0, carry0=1 | 11 PASS H=A, Co=0.
//   Co semantics: ADD/INC carry out; SUB Co=1 means no borrow (A>=B unsigned).
//  FSM IDLE: in_ready=1; in_valid&in_ready at edge -> load a_sh=a, b_sh=b, op_r=op, carry=carry0, cnt=0 -> RUN.
//  FSM RUN: each edge: slice on a_sh[0], b_sh[0], carry, op_r; result shifts right with H entering at MSB.
//   Carry <= Co; a_sh/b_sh shift right; cnt++.
//   At cnt==W-1 -> DONE; co <= final Co.
//  FSM DONE: out_valid=1; result/co held stable; out_ready -> IDLE same edge.
//   in_ready=0 in RUN and DONE, so no new op is accepted until DONE retires (no overlap).
//  Latency: handshake at edge k -> out_valid high from edge k+W, ADD/SUB/INC/PASS identical.
//   Throughput: one op per W+1 cycles with out_ready tied high.
//  in_valid ignored outside IDLE; a/b/op/ci sampled only at accept edge and may change afterwards.
//  out_ready while out_valid=0 has no effect. result keeps last value in IDLE until the next DONE overwrites it.
//  Width: no truncation beyond W; carry beyond MSB only on co.
// CONFIGURATION
//  ARITH_FLAGS_EN defined: adds ports zero (result==0) and ovf (signed overflow).
//   ovf = carry into MSB ^ carry out of MSB; forced 0 for PASS.
//   Both flags registered at entry to DONE, reset 0, held with result.
//  ARITH_FLAGS_EN undefined: ports zero/ovf and their logic absent; all other behaviour identical.
// STRUCTURE
//  Package arith_pkg:
//   typedef enum logic[1:0] arith_op_e {OP_ADD=2'b00, OP_SUB=2'b01, OP_INC=2'b10, OP_PASS=2'b11}
//   typedef enum logic[1:0] sau_state_e {S_IDLE, S_RUN, S_DONE}
//   function carry0(op,ci) returning the initial carry per opcode
//  Sub-module arith_bit_slice: combinational 1-bit slice (Ai,Bi,Ci,S1,S0 -> H,Co), one instance.
//  Top holds FSM, counter, shift registers, carry flop.
// TESTING (W=8, out_ready=1 unless stated)
//  ADD a=0x3C b=0x0F ci=0 -> result=0x4B co=0, out_valid exactly 8 cycles after accept.
//  ADD a=0xFF b=0x01 ci=0 -> 0x00 co=1. SUB 0x10-0x01 -> 0x0F co=1. SUB 0x00-0x01 -> 0xFF co=0.
//  INC a=0xFF -> 0x00 co=1. PASS a=0xA5 b=0x5A -> 0xA5 co=0.
//   With ARITH_FLAGS_EN: ADD 0x7F+0x01 -> ovf=1 zero=0; INC 0xFF -> zero=1.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> result/co stable, in_ready=0.
//   A new in_valid pulse during this window is not accepted.
//  rst_n low mid-RUN (cnt=3) -> async: out_valid=0, in_ready=1 after release; next ADD gives correct result.
//  Random: 1000 random op/a/b/ci with random valid/ready stalls vs reference model; check result/co/flags.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared opcode/state encodings and initial-carry helper for the serial arithmetic unit.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_INC  = 2'b10,
    OP_PASS = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sau_state_e;

  // SUB is A + ~B + 1 and INC is A + 0 + 1, so both start with carry set.
  function automatic logic carry0(input arith_op_e op, input logic ci);
    logic c;
    case (op)
      OP_ADD:         c = ci;
      OP_SUB, OP_INC: c = 1'b1;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arith_bit_slice.sv
// Combinational 1-bit arithmetic slice: {S1,S0} selects B, ~B or 0 as the addend; PASS forwards A with no carry.
module arith_bit_slice
  import arith_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_s1,
  input  logic i_s0,
  output logic o_h,
  output logic o_co
);

  logic w_bm;
  logic w_pass;

  always_comb begin
    w_bm   = 1'b0;
    w_pass = 1'b0;
    case (arith_op_e'({i_s1, i_s0}))
      OP_ADD:  w_bm = i_b;
      OP_SUB:  w_bm = ~i_b;
      OP_INC:  w_bm = 1'b0;
      default: w_pass = 1'b1;
    endcase
    o_h  = w_pass ? i_a : (i_a ^ w_bm ^ i_c);
    o_co = w_pass ? 1'b0 : ((i_a & w_bm) | (i_a & i_c) | (w_bm & i_c));
  end

endmodule

// File: rtl/serial_arith_unit.sv
// Bit-serial W-bit ADD/SUB/INC/PASS, LSB first; result valid W cycles after accept, held in DONE until out_ready.
// No overlap: in_ready only in IDLE. ARITH_FLAGS_EN adds registered zero/ovf outputs.
module serial_arith_unit
  import arith_pkg::*;
#(
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         co
`ifdef ARITH_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  sau_state_e       r_state, w_state_nxt;
  logic [W-1:0]     r_a_sh, r_b_sh;
  logic [W-2:0]     r_res_sh;
  arith_op_e        r_op;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             r_co;
  logic [1:0]       w_op_bits;
  logic             w_h, w_co, w_last;
  logic [W-1:0]     w_res_nxt;

  assign w_op_bits = r_op;
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_res_nxt = {w_h, r_res_sh};

  arith_bit_slice u_slice (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_c  (r_carry),
    .i_s1 (w_op_bits[1]),
    .i_s0 (w_op_bits[0]),
    .o_h  (w_h),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_op     <= OP_ADD;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_co     <= 1'b0;
    end else if (in_ready && in_valid) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_op    <= arith_op_e'(op);
      r_carry <= carry0(arith_op_e'(op), ci);
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_nxt[W-1:1];
      r_carry  <= w_co;
      r_cnt    <= r_cnt + CNT_W'(1);
      // result/co only move on DONE entry so the consumer never sees partial bits
      if (w_last) begin
        r_result <= w_res_nxt;
        r_co     <= w_co;
      end
    end
  end

  assign result = r_result;
  assign co     = r_co;

`ifdef ARITH_FLAGS_EN
  logic r_zero, r_ovf;

  // r_carry is the carry into the MSB while the last bit is in the slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_zero <= ~|w_res_nxt;
      r_ovf  <= (r_op != OP_PASS) & (r_carry ^ w_co);
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed vector table, backpressure / mid-RUN reset sequences and a random run against a reference model.
module tb_serial_arith_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       ci = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       co;
`ifdef ARITH_FLAGS_EN
  logic       zero, ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_arith_unit #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .co        (co)
`ifdef ARITH_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_res;
    logic       exp_co;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: returns {co, result}
  function automatic logic [8:0] ref_calc(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
    logic [8:0] r;
    case (o)
      2'b00:   r = {1'b0, x} + {1'b0, y} + {8'b0, c};
      2'b01:   r = {1'b0, x} + {1'b0, ~y} + 9'd1;
      2'b10:   r = {1'b0, x} + 9'd1;
      default: r = {1'b0, x};
    endcase
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic [7:0] r);
    logic v;
    case (o)
      2'b00:   v = (x[7] == y[7]) && (r[7] != x[7]);
      2'b01:   v = (x[7] != y[7]) && (r[7] != x[7]);
      2'b10:   v = (x == 8'h7F);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Entered and left at #1 after a rising edge; returns in DONE (or on timeout).
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input logic c,
                        output int lat);
    int n;
    in_valid = 1'b1;
    op = o; a = x; b = y; ci = c;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire(input int stall);
    if (stall > 0) out_ready = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_to_idle", {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int stall;
    logic [8:0] exp;
    logic [7:0] hold_res;
    logic hold_co;
    logic seen_valid;

    vecs[0] = '{2'b00, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{2'b01, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1};
    vecs[3] = '{2'b01, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{2'b10, 8'hFF, 8'h33, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{2'b11, 8'hA5, 8'h5A, 1'b1, 8'hA5, 1'b0};
    vecs[6] = '{2'b00, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", {24'b0, result}, 32'd0);
    chk("reset_co", {31'b0, co}, 32'd0);
`ifdef ARITH_FLAGS_EN
    chk("reset_flags", {30'b0, zero, ovf}, 32'd0);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_result", i), {24'b0, result}, {24'b0, vecs[i].exp_res});
      chk($sformatf("vec%0d_co", i), {31'b0, co}, {31'b0, vecs[i].exp_co});
      chk($sformatf("vec%0d_in_ready_done", i), {31'b0, in_ready}, 32'd0);
      retire(0);
      chk($sformatf("vec%0d_result_held_idle", i), {24'b0, result}, {24'b0, vecs[i].exp_res});
    end

`ifdef ARITH_FLAGS_EN
    run_op(2'b00, 8'h7F, 8'h01, 1'b0, lat);
    chk("flags_add7f_ovf", {31'b0, ovf}, 32'd1);
    chk("flags_add7f_zero", {31'b0, zero}, 32'd0);
    retire(0);
    run_op(2'b10, 8'hFF, 8'h00, 1'b0, lat);
    chk("flags_incff_zero", {31'b0, zero}, 32'd1);
    chk("flags_incff_ovf", {31'b0, ovf}, 32'd0);
    retire(0);
`endif

    // Backpressure: hold DONE for 5 cycles while offering a new op
    out_ready = 1'b0;
    run_op(2'b00, 8'h55, 8'h22, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd8);
    hold_res = result;
    hold_co  = co;
    chk("bp_result", {24'b0, hold_res}, 32'h77);
    in_valid = 1'b1; op = 2'b11; a = 8'h11; b = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {22'b0, out_valid, in_ready, result},
          {22'b0, 1'b1, 1'b0, hold_res});
      chk($sformatf("bp_co%0d", k), {31'b0, co}, {31'b0, hold_co});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_retired", {30'b0, out_valid, in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen_valid |= out_valid;
    end
    chk("bp_no_ghost_op", {31'b0, seen_valid}, 32'd0);

    // Async reset three bits into RUN aborts the op
    in_valid = 1'b1; op = 2'b00; a = 8'hF0; b = 8'h0F; ci = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_run_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_run_result", {24'b0, result}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen_valid |= out_valid;
    end
    chk("rst_aborted_no_result", {31'b0, seen_valid}, 32'd0);
    run_op(2'b00, 8'h12, 8'h34, 1'b1, lat);
    chk("rst_next_add_latency", 32'(lat), 32'd8);
    chk("rst_next_add_result", {23'b0, co, result}, 32'h047);
    retire(0);

    for (int t = 0; t < 1000; t++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb;
      logic       rc;
      ro = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = ref_calc(ro, ra, rb, rc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(ro, ra, rb, rc, lat);
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'd8);
      chk($sformatf("rnd%0d_res_co op=%0d a=%0h b=%0h ci=%0d", t, ro, ra, rb, rc),
          {23'b0, co, result}, {23'b0, exp});
`ifdef ARITH_FLAGS_EN
      chk($sformatf("rnd%0d_flags", t), {30'b0, zero, ovf},
          {30'b0, (exp[7:0] == 8'h00), ref_ovf(ro, ra, rb, exp[7:0])});
`endif
      stall = $urandom_range(0, 3);
      retire(stall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
